// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add/subtract through one 4-bit CLA slice, one nibble per clock.
module cla_adder_4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] s_o,
  output logic       cout_o
);
  logic [3:0] g, p;
  logic [4:0] c;
  assign g = a_i & b_i;
  assign p = a_i ^ b_i;
  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & cin_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin_i);
  assign s_o = p ^ c[3:0];
  assign cout_o = c[4];
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NIB = WIDTH / 4;
  localparam int IW = $clog2(NIB);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [3:0] slice_s;
  logic slice_c;
  cla_adder_4 u_slice (
    .a_i   (op_a_q[4*idx_q +: 4]),
    .b_i   (op_b_q[4*idx_q +: 4]),
    .cin_i (carry_q),
    .s_o   (slice_s),
    .cout_o(slice_c)
  );
  always_comb begin
    state_d = state_q;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    sum_d = sum_q;
    idx_d = idx_q;
    carry_d = carry_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        op_a_d = a;
        op_b_d = op_sub ? ~b : b;
        carry_d = op_sub;
        idx_d = '0;
        sum_d = '0;
        cout_d = 1'b0;
        ovf_d = 1'b0;
      end
      RUN: begin
        sum_d[4*idx_q +: 4] = slice_s;
        carry_d = slice_c;
        if (idx_q == IW'(NIB-1)) begin
          state_d = DONE;
          cout_d = slice_c;
          ovf_d = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) && (slice_s[3] != op_a_q[WIDTH-1]);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_a_q <= '0;
      op_b_q <= '0;
      sum_q <= '0;
      idx_q <= '0;
      carry_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      sum_q <= sum_d;
      idx_q <= idx_d;
      carry_q <= carry_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign sum = sum_q;
  assign cout = cout_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed and random checks of the serial adder against an arithmetic model.
module tb_nibble_serial_adder;
  localparam int W = 16;
  localparam int NIB = W / 4;
  logic clk = 0, rst = 1, start = 0, op_sub = 0;
  logic [W-1:0] a = '0, b = '0, sum;
  logic busy, done, cout, ovf;
  int total = 0, bad = 0;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for carry, signed range for overflow.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       output logic [W-1:0] r, output logic c, output logic v);
    int xs, ys, sr;
    xs = $signed(x);
    ys = $signed(y);
    sr = s ? xs - ys : xs + ys;
    r = s ? x - y : x + y;
    c = s ? (x >= y) : ((int'(x) + int'(y)) > (2**W - 1));
    v = (sr > 2**(W-1) - 1) || (sr < -(2**(W-1)));
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, n, NIB + 1);
    chk({tag, " busy@done"}, busy, 1);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [W-1:0] r;
    logic c, v;
    model(x, y, s, r, c, v);
    chk({tag, " sum"}, sum, r);
    chk({tag, " cout"}, cout, c);
    chk({tag, " ovf"}, ovf, v);
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input string tag);
    logic [W-1:0] r;
    logic c, v;
    start = 1; a = x; b = y; op_sub = s;
    @(posedge clk); #1;
    start = 0; a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom);
    chk({tag, " busy@run"}, busy, 1);
    wait_done(tag);
    check_result(tag, x, y, s);
    @(posedge clk); #1;
    model(x, y, s, r, c, v);
    chk({tag, " done pulse"}, done, 0);
    chk({tag, " busy after"}, busy, 0);
    chk({tag, " sum held"}, sum, r);
  endtask

  initial begin
    int dn;
    logic [W-1:0] rx, ry;
    logic rs;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst sum", sum, 0);
    chk("rst cout", cout, 0);
    chk("rst ovf", ovf, 0);
    rst = 0;
    @(posedge clk); #1;

    do_op(16'h1234, 16'h4321, 0, "add1");
    do_op(16'hFFFF, 16'h0001, 0, "ripple");
    do_op(16'h7FFF, 16'h0001, 0, "addovf");
    do_op(16'h0005, 16'h0007, 1, "subneg");
    do_op(16'h8000, 16'h0001, 1, "subovf");

    // start held high; operands change right after acceptance
    start = 1; a = 16'h1111; b = 16'h2222; op_sub = 0;
    @(posedge clk); #1;
    a = 16'h0F0F; b = 16'h0101; op_sub = 1;
    wait_done("b2b first");
    check_result("b2b first", 16'h1111, 16'h2222, 0);
    @(posedge clk); #1;
    chk("b2b idle gap", busy, 0);
    @(posedge clk); #1;
    start = 0;
    chk("b2b accept", busy, 1);
    wait_done("b2b second");
    check_result("b2b second", 16'h0F0F, 16'h0101, 1);
    @(posedge clk); #1;

    // reset in the third RUN cycle
    start = 1; a = 16'h1234; b = 16'h4321; op_sub = 0;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort sum", sum, 0);
    chk("abort cout", cout, 0);
    chk("abort ovf", ovf, 0);
    dn = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("abort no done", dn, 0);
    do_op(16'h00FF, 16'h0001, 0, "after abort");

    for (int i = 0; i < 24; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      rs = 1'($urandom);
      if (i % 6 == 0) ry = rx;
      do_op(rx, ry, rs, $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
